// File: rtl/stream_wr_scheduler_pkg.sv
// stream_wr_scheduler_pkg: shared widths, defaults and FSM encoding for the stream write scheduler
package stream_wr_scheduler_pkg;
  localparam int DATA_W = 32;
  localparam int MEM_AW_DEF = 22;
  localparam int BURST_LEN_DEF = 8;
  typedef enum logic [2:0] {IDLE, ARB, WR_REQ, WR_DATA, RD_REQ, RD_WAIT} state_t;
endpackage

// File: rtl/stream_wr_scheduler_fifo.sv
// stream_fifo: synchronous show-ahead FIFO with occupancy, full and empty
module stream_fifo
  import stream_wr_scheduler_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level[AW];
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // head reads as zero when empty so the data port is clean straight out of reset
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/stream_wr_scheduler.sv
// stream_wr_scheduler: buffers generator words and schedules write bursts against checker reads on one SDRAM port
module stream_wr_scheduler
  import stream_wr_scheduler_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int HIGH_WM = 14,
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              stop,
  output logic              gen_en,
  input  logic [DATA_W-1:0] s32,
  input  logic              n32rdy,
  input  logic              rd_req,
  input  logic [MEM_AW-1:0] rd_addr,
  output logic              rd_grant,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_wnext,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  output logic [MEM_AW-1:0] wr_ptr,
  output logic [FIFO_AW:0]  level,
  output logic              ovf,
  output logic              err,
  output logic              running
);
  localparam int LW = FIFO_AW + 1;
  localparam logic [LW-1:0] BL = LW'(BURST_LEN);
  localparam logic [LW-1:0] HW = LW'(HIGH_WM);
  state_t state;
  logic last_wr, full, empty, pop, clr, wr_ok, go_wr;
  logic [7:0] beat, beat_n;
  assign pop = mem_wnext && state == WR_DATA;
  assign clr = state == IDLE && start && !stop;
  assign wr_ok = level >= BL;
  // urgent writes beat the alternation; otherwise a pending read takes its turn after a write
  assign go_wr = wr_ok && (level >= HW || !rd_req || !last_wr);
  assign rd_grant = state == RD_REQ && mem_ack;
  assign beat_n = beat + 8'(pop && !empty);
  stream_fifo #(.AW(FIFO_AW), .DW(DATA_W)) u_fifo (
    .clk(clk), .n_rst(n_rst), .clr(clr), .push(n32rdy), .pop(pop), .din(s32),
    .dout(mem_wdata), .level(level), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      last_wr <= 1'b0;
      beat <= '0;
      gen_en <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      wr_ptr <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
      running <= 1'b0;
    end else begin
      gen_en <= running && level < HW;
      if (n32rdy && full) ovf <= 1'b1;
      if (pop && empty) err <= 1'b1;
      if (stop) running <= 1'b0;
      case (state)
        IDLE:
          if (clr) begin
            wr_ptr <= '0;
            ovf <= 1'b0;
            err <= 1'b0;
            running <= 1'b1;
            state <= ARB;
          end
        ARB:
          if (go_wr) begin
            mem_req <= 1'b1;
            mem_we <= 1'b1;
            mem_addr <= wr_ptr;
            last_wr <= 1'b1;
            state <= WR_REQ;
          end else if (rd_req) begin
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= rd_addr;
            last_wr <= 1'b0;
            state <= RD_REQ;
          end else if (!running) state <= IDLE;
        WR_REQ:
          if (mem_ack) begin
            mem_req <= 1'b0;
            beat <= '0;
            state <= WR_DATA;
          end
        WR_DATA: begin
          beat <= beat_n;
          if (mem_done) begin
            if (beat_n != 8'(BURST_LEN)) err <= 1'b1;
            wr_ptr <= wr_ptr + MEM_AW'(BURST_LEN);
            state <= ARB;
          end
        end
        RD_REQ:
          if (mem_ack) begin
            mem_req <= 1'b0;
            state <= RD_WAIT;
          end
        RD_WAIT:
          if (mem_done) state <= ARB;
        default: state <= IDLE;
      endcase
    end
endmodule
